muldiv_unit: RTL

- Multi-cycle execute unit that sits directly downstream of the register bank.
- Consumes the two register read operands and computes 32-bit unsigned multiply (low or high word), divide or remainder using a 32-iteration shift-add / restoring-subtract datapath.
- Returns the result to the register bank write port as a destination address, write data and a one-cycle write strobe.
- Handshake is start/busy/done, so the decode/issue logic stalls while the unit is running.

---
 rtl/muldiv_unit_if.sv | 36 +++
 rtl/muldiv_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_if
// Description : Issue/retire bundle between decode, register bank and the
//               multi-cycle multiply/divide unit.
//               master : issue side (drives start/op/operands/destination,
//                        observes busy/done/write-back)
//               slave  : the execute unit itself
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              start;
  logic [1:0]        op;
  logic [WIDTH-1:0]  rs1_data;
  logic [WIDTH-1:0]  rs2_data;
  logic [ADDR_W-1:0] rd_addr_in;
  logic              busy;
  logic              done;
  logic              rd_we;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;

  modport master (
    output start, op, rs1_data, rs2_data, rd_addr_in,
    input  busy, done, rd_we, rd_addr, rd_data
  );

  modport slave (
    input  start, op, rs1_data, rs2_data, rd_addr_in,
    output busy, done, rd_we, rd_addr, rd_data
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Multi-cycle unsigned MUL / MULHU / DIVU / REMU execute unit.
//               One shift-add or restoring-subtract step per clock, 32 steps,
//               result returned as a register-bank write.
// Ports       : clk  - system clock, rising edge
//               rst  - asynchronous active-high reset
//               mdu  - slave side of muldiv_unit_if:
//                      start/op/rs1_data/rs2_data/rd_addr_in in,
//                      busy/done/rd_we/rd_addr/rd_data out
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave mdu
);

  localparam int                 CNT_W    = $clog2(WIDTH) + 1;
  // Iterations run with the counter at 0..WIDTH-1; the terminal count WIDTH
  // spends one extra RUN cycle registering the selected result into DONE.
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [1:0]          op_q;
  logic [WIDTH-1:0]    a_q;        // multiplicand / dividend (shifts left for divide)
  logic [WIDTH-1:0]    b_q;        // multiplier (shifts right) / divisor
  logic [ADDR_W-1:0]   rd_q;
  logic [2*WIDTH-1:0]  acc_q;      // {hi, lo}: product, or {remainder, quotient}
  logic                busy_q;
  logic                done_q;
  logic                we_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [WIDTH-1:0]    rd_data_q;

  logic [WIDTH:0]      mul_sum_d;
  logic [WIDTH:0]      rem_sh_d;
  logic [WIDTH+1:0]    diff_d;
  logic                borrow_d;
  logic [2*WIDTH-1:0]  acc_d;

  // One iteration of either datapath. op_q[1] selects divide.
  always_comb begin
    mul_sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
    // Partial remainder with the next dividend bit (MSB first) shifted in.
    rem_sh_d  = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    // Extra headroom bit keeps the borrow unambiguous for any 33-bit trial.
    diff_d    = {1'b0, rem_sh_d} - {2'b00, b_q};
    borrow_d  = diff_d[WIDTH+1];
    if (!op_q[1]) begin
      // Shift-add: carry and sum enter the top, product bits walk down.
      acc_d = {mul_sum_d, acc_q[WIDTH-1:1]};
    end else begin
      // Restoring step: keep the shifted remainder on borrow, else the
      // difference; quotient bit is the inverse of the borrow. A zero
      // divisor never borrows, giving all-ones quotient and rem = dividend.
      acc_d = {(borrow_d ? rem_sh_d[WIDTH-1:0] : diff_d[WIDTH-1:0]),
               acc_q[WIDTH-2:0], ~borrow_d};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mdu.start) begin
            state_q <= S_RUN;
            op_q    <= mdu.op;
            a_q     <= mdu.rs1_data;
            b_q     <= mdu.rs2_data;
            rd_q    <= mdu.rd_addr_in;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          if (cnt_q != LAST_CNT) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (op_q[1]) begin
              a_q <= a_q << 1;
            end else begin
              b_q <= b_q >> 1;
            end
          end else begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            we_q      <= (rd_q != '0);
            rd_addr_q <= rd_q;
            // op_q[0] picks the high half: MULHU product hi, REMU remainder.
            rd_data_q <= op_q[0] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mdu.busy    = busy_q;
  assign mdu.done    = done_q;
  assign mdu.rd_we   = we_q;
  assign mdu.rd_addr = rd_addr_q;
  assign mdu.rd_data = rd_data_q;

endmodule
`default_nettype wire
